// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with N/V/Z flag register; ALU_PIPE_SAT_EN enables signed saturation on ADD/SUB/PCS.
// Latency: result valid two cycles after input accept, one op per cycle sustained.
// Backpressure: S2 holds while out_ready is low, S1 holds behind it, in_ready drops once S1 is occupied.
module alu_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [2:0]       out_nvz,
  output logic [2:0]       flags
);

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_RED    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_PCS    = 4'hE;

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic             s1_valid_q;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s2_valid_q;
  logic [3:0]       s2_op_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       nvz_q, nvz_d;
  logic [2:0]       flags_q, flags_d;

  logic             s2_take;
  logic [WIDTH-1:0] sum_w, diff_w, add_r, sub_r, red_r, pad_r, ror_r, mem_r;
  logic             ovf_add, ovf_sub;
  logic [SHAMT_W-1:0] sh;
  logic [SHAMT_W:0]   lsh;
  logic [4:0]       lane;

  assign s2_take   = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_take;
  assign out_valid = s2_valid_q;
  assign out_res   = res_q;
  assign out_nvz   = nvz_q;
  assign flags     = flags_q;

  always_comb begin
    sh      = s1_b_q[SHAMT_W-1:0];
    lsh     = (SHAMT_W+1)'(WIDTH) - {1'b0, sh};
    sum_w   = s1_a_q + s1_b_q;
    diff_w  = s1_a_q - s1_b_q;
    ovf_add = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
    ovf_sub = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
    add_r = ovf_add ? (s1_a_q[WIDTH-1] ? SAT_NEG : SAT_POS) : sum_w;
    sub_r = ovf_sub ? (s1_a_q[WIDTH-1] ? SAT_NEG : SAT_POS) : diff_w;
`else
    add_r = sum_w;
    sub_r = diff_w;
`endif

    red_r = '0;
    for (int i = 0; i < WIDTH/8; i++) begin
      red_r = red_r + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
                    + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
    end

    // Nibble lanes: a 5-bit sum whose top two bits disagree has overflowed.
    pad_r = '0;
    lane  = '0;
    for (int i = 0; i < WIDTH/4; i++) begin
      lane = {s1_a_q[4*i+3], s1_a_q[4*i +: 4]} + {s1_b_q[4*i+3], s1_b_q[4*i +: 4]};
      if (lane[4] != lane[3]) pad_r[4*i +: 4] = lane[4] ? 4'h8 : 4'h7;
      else                    pad_r[4*i +: 4] = lane[3:0];
    end

    ror_r = (s1_a_q >> sh) | (s1_a_q << lsh);
    mem_r = {s1_a_q[WIDTH-1:1], 1'b0} + {s1_b_q[WIDTH-2:0], 1'b0};

    res_d = '0;
    case (s1_op_q)
      OP_ADD, OP_PCS: res_d = add_r;
      OP_SUB:         res_d = sub_r;
      OP_RED:         res_d = red_r;
      OP_XOR:         res_d = s1_a_q ^ s1_b_q;
      OP_SLL:         res_d = s1_a_q << sh;
      OP_SRA:         res_d = WIDTH'($signed(s1_a_q) >>> sh);
      OP_ROR:         res_d = ror_r;
      OP_PADDSB:      res_d = pad_r;
      OP_LW, OP_SW:   res_d = mem_r;
      OP_LHB:         res_d = {s1_b_q[7:0], s1_a_q[WIDTH-9:0]};
      OP_LLB:         res_d = {s1_a_q[WIDTH-1:8], s1_b_q[7:0]};
      default:        res_d = '0;
    endcase

    nvz_d = '0;
    case (s1_op_q)
      OP_ADD:                         nvz_d = {add_r[WIDTH-1], ovf_add, add_r == '0};
      OP_SUB:                         nvz_d = {sub_r[WIDTH-1], ovf_sub, sub_r == '0};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: nvz_d = {2'b00, res_d == '0};
      default:                        nvz_d = '0;
    endcase
  end

  // Logic ops only own Z; N and V keep whatever the last ADD/SUB left.
  always_comb begin
    flags_d = flags_q;
    if (s2_valid_q && out_ready) begin
      case (s2_op_q)
        OP_ADD, OP_SUB:                 flags_d = nvz_q;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d = {flags_q[2:1], nvz_q[0]};
        default:                        flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= '0;
      res_q      <= '0;
      nvz_q      <= '0;
      flags_q    <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q <= in_op;
          s1_a_q  <= in_a;
          s1_b_q  <= in_b;
        end
      end
      if (s2_take) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_op_q <= s1_op_q;
          res_q   <= res_d;
          nvz_q   <= nvz_d;
        end
      end
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16: opcode vector table plus stall, flush and async-reset sequences.
module tb_alu_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic [2:0]   out_nvz;
  logic [2:0]   flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_nvz(out_nvz),
    .flags(flags)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  nvz;
    logic [2:0]  flg;
  } vec_t;

  vec_t vt[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int  cyc;
    bit  seen;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = vt[i].op;
    in_a      = vt[i].a;
    in_b      = vt[i].b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL vec%0d timeout: out_valid never rose", i);
    end else begin
      check($sformatf("vec%0d latency", i), cyc, 2);
      check($sformatf("vec%0d res", i), out_res, vt[i].res);
      check($sformatf("vec%0d nvz", i), out_nvz, vt[i].nvz);
      @(negedge clk);
      check($sformatf("vec%0d flags", i), flags, vt[i].flg);
      check($sformatf("vec%0d drained", i), out_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] bvals[4];
    logic [2:0]  saved_flags;
    int          sent;
    int          recv;

    //        op     a         b         res       nvz     flags after commit
`ifdef ALU_PIPE_SAT_EN
    vt[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 3'b010};
    vt[1]  = '{4'h3, 16'h00FF, 16'h00FF, 16'h0000, 3'b001, 3'b011};
`else
    vt[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 3'b110};
    vt[1]  = '{4'h3, 16'h00FF, 16'h00FF, 16'h0000, 3'b001, 3'b111};
`endif
    vt[2]  = '{4'h1, 16'h1234, 16'h1234, 16'h0000, 3'b001, 3'b001};
    vt[3]  = '{4'h3, 16'h00FF, 16'h00FF, 16'h0000, 3'b001, 3'b001};
    vt[4]  = '{4'h2, 16'h7F80, 16'h0101, 16'h0001, 3'b000, 3'b001};
    vt[5]  = '{4'h5, 16'h8000, 16'h000F, 16'hFFFF, 3'b000, 3'b000};
    vt[6]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b000, 3'b000};
    vt[7]  = '{4'h7, 16'h7777, 16'h1111, 16'h7777, 3'b000, 3'b000};
    vt[8]  = '{4'h4, 16'h0001, 16'h0014, 16'h0010, 3'b000, 3'b000};
    vt[9]  = '{4'h4, 16'h1234, 16'h0010, 16'h1234, 3'b000, 3'b000};
`ifdef ALU_PIPE_SAT_EN
    vt[10] = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 3'b110, 3'b110};
`else
    vt[10] = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 3'b010, 3'b010};
`endif
    vt[11] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 3'b001, 3'b001};
    vt[12] = '{4'h8, 16'h1001, 16'h0004, 16'h1008, 3'b000, 3'b001};
    vt[13] = '{4'hA, 16'h1234, 16'h00AB, 16'hAB34, 3'b000, 3'b001};
    vt[14] = '{4'hB, 16'h1234, 16'h00AB, 16'h12AB, 3'b000, 3'b001};
`ifdef ALU_PIPE_SAT_EN
    vt[15] = '{4'hE, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b000, 3'b001};
`else
    vt[15] = '{4'hE, 16'h7FFF, 16'h0001, 16'h8000, 3'b000, 3'b001};
`endif
    vt[16] = '{4'hC, 16'h1234, 16'h0001, 16'h0000, 3'b000, 3'b001};
    vt[17] = '{4'h6, 16'h1234, 16'h0000, 16'h1234, 3'b000, 3'b000};
    vt[18] = '{4'h7, 16'h8888, 16'h8888, 16'h8888, 3'b000, 3'b000};
    vt[19] = '{4'h2, 16'hFFFF, 16'hFFFF, 16'hFFFC, 3'b000, 3'b000};
    vt[20] = '{4'h9, 16'hFFFF, 16'h8001, 16'h0000, 3'b000, 3'b000};
`ifdef ALU_PIPE_SAT_EN
    vt[21] = '{4'h0, 16'h8000, 16'h8000, 16'h8000, 3'b110, 3'b110};
    vt[22] = '{4'h7, 16'h1234, 16'h1111, 16'h2345, 3'b000, 3'b110};
    vt[23] = '{4'h5, 16'h4000, 16'h0001, 16'h2000, 3'b000, 3'b110};
`else
    vt[21] = '{4'h0, 16'h8000, 16'h8000, 16'h0000, 3'b011, 3'b011};
    vt[22] = '{4'h7, 16'h1234, 16'h1111, 16'h2345, 3'b000, 3'b011};
    vt[23] = '{4'h5, 16'h4000, 16'h0001, 16'h2000, 3'b000, 3'b010};
`endif

    // Reset state
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_res", out_res, 0);
    check("reset out_nvz", out_nvz, 0);
    check("reset flags", flags, 0);
    check("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) run_vec(i);

    // Burst of four with a three-cycle output stall
    bvals[0] = 16'h0011; bvals[1] = 16'h0022; bvals[2] = 16'h0033; bvals[3] = 16'h0044;
    sent  = 0;
    recv  = 0;
    in_op = 4'hB;
    in_a  = 16'h0000;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      in_b      = (sent < 4) ? bvals[sent] : 16'h0000;
      #1;
      if (cyc == 2) check("burst in_ready after 2 accepts", in_ready, 0);
      if (cyc >= 2 && cyc <= 4) begin
        check($sformatf("burst stall%0d out_valid", cyc), out_valid, 1);
        check($sformatf("burst stall%0d out_res", cyc), out_res, bvals[0]);
      end
      if (out_valid && out_ready) begin
        check($sformatf("burst result%0d", recv), out_res, bvals[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("burst results delivered", recv, 4);
    @(negedge clk);
    in_valid = 1'b0;
    check("burst no duplicate", out_valid, 0);
    check("burst flags untouched", flags, vt[23].flg);

    // Flush with both stages full and the consumer ready
    saved_flags = flags;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 4'h1;
    in_a      = 16'h0000;
    in_b      = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("flush pre out_valid", out_valid, 1);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_op     = 4'hB;
    #1;
    check("flush in_ready", in_ready, 1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", out_valid, 0);
    check("flush flags held", flags, saved_flags);
    @(negedge clk);
    check("flush s1 cleared", out_valid, 0);
    @(negedge clk);
    check("flush input dropped", out_valid, 0);
    check("flush flags still held", flags, saved_flags);

    // Async reset with work in flight
    in_valid = 1'b1;
    in_op    = 4'h1;
    in_a     = 16'h0000;
    in_b     = 16'h0001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset flags", flags, 3'b100);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst flags", flags, 0);
    check("async rst out_res", out_res, 0);
    check("async rst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset nothing in flight", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
